// File: rtl/mc_pkg.sv
// Shared encodings and service-FSM state type for the memory-controller
// port responder.
package mc_pkg;

    localparam logic [2:0] RQ_CMD_RD       = 3'd1;
    localparam logic [2:0] RQ_CMD_WR       = 3'd2;
    localparam logic [2:0] RS_CMD_RD_DATA  = 3'd2;
    localparam logic [2:0] RS_CMD_WR_CMPLT = 3'd3;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } svc_state_t;

endpackage

// File: rtl/mc_req_fifo.sv
// Request FIFO: power-of-2 depth, first-word fall-through read, occupancy count.
// The caller only pushes when there is room (or when popping the same cycle).
module mc_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Payload storage needs no reset; pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/mc_port_responder.sv
// Memory-controller port model: queues personality requests, services each
// after LATENCY cycles against a local backing store, and returns responses in order.
module mc_port_responder
    import mc_pkg::*;
#(
    parameter int RTNCTL_WIDTH = 32,
    parameter int FIFO_DEPTH   = 8,
    parameter int LATENCY      = 4,
    parameter int MEM_WORDS    = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mc_rq_vld,
    input  logic [2:0]              mc_rq_cmd,
    input  logic [3:0]              mc_rq_scmd,
    input  logic [47:0]             mc_rq_vadr,
    input  logic [1:0]              mc_rq_size,
    input  logic [63:0]             mc_rq_data,
    input  logic [RTNCTL_WIDTH-1:0] mc_rq_rtnctl,
    input  logic                    mc_rq_flush,
    output logic                    mc_rq_stall,
    output logic                    mc_rs_vld,
    output logic [2:0]              mc_rs_cmd,
    output logic [3:0]              mc_rs_scmd,
    output logic [63:0]             mc_rs_data,
    output logic [RTNCTL_WIDTH-1:0] mc_rs_rtnctl,
    input  logic                    mc_rs_stall,
    output logic                    mc_rs_flush_cmplt,
    output logic                    err_ovf
);

    localparam int IDXW = $clog2(MEM_WORDS);
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;
    localparam int QW   = 3 + 4 + IDXW + 64 + RTNCTL_WIDTH;

    logic [QW-1:0]           q_rdata;
    logic [CW-1:0]           q_count, occ_next;
    logic                    q_full, q_empty, push, pop;
    svc_state_t              state, state_n;
    logic [7:0]              cnt, cnt_n;
    logic                    access;
    logic [2:0]              cur_cmd;
    logic [3:0]              cur_scmd;
    logic [IDXW-1:0]         cur_idx;
    logic [63:0]             cur_data;
    logic [RTNCTL_WIDTH-1:0] cur_rtnctl;
    logic                    cur_wr;
    logic [63:0]             mem [MEM_WORDS];
    logic                    flush_pend, flush_done;
    logic                    unused_ok;

    // Size is ignored (64-bit only) and only the word-index bits of vadr matter.
    assign unused_ok = ^{mc_rq_size, mc_rq_vadr};

    assign pop    = !q_empty && ((state == IDLE) || ((state == RESP) && !mc_rs_stall));
    // A push is legal when full only if a pop frees the slot in the same cycle.
    assign push   = mc_rq_vld && (!q_full || pop);
    assign cur_wr = (cur_cmd == RQ_CMD_WR);
    assign occ_next   = q_count + CW'(push) - CW'(pop);
    assign flush_done = flush_pend && q_empty && (state == IDLE) && !push;
    assign mc_rs_vld  = (state == RESP);

    mc_req_fifo #(
        .WIDTH (QW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata ({mc_rq_cmd, mc_rq_scmd, mc_rq_vadr[3 +: IDXW], mc_rq_data, mc_rq_rtnctl}),
        .pop   (pop),
        .rdata (q_rdata),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        access  = 1'b0;
        case (state)
            IDLE: begin
                if (!q_empty) begin
                    state_n = WAIT;
                    cnt_n   = 8'(LATENCY);
                end
            end
            WAIT: begin
                cnt_n = cnt - 8'd1;
                if (cnt == 8'd1) begin
                    state_n = RESP;
                    access  = 1'b1;
                end
            end
            RESP: begin
                if (!mc_rs_stall) begin
                    if (!q_empty) begin
                        state_n = WAIT;
                        cnt_n   = 8'(LATENCY);
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            cnt               <= '0;
            {cur_cmd, cur_scmd, cur_idx, cur_data, cur_rtnctl} <= '0;
            mc_rs_cmd         <= '0;
            mc_rs_scmd        <= '0;
            mc_rs_data        <= '0;
            mc_rs_rtnctl      <= '0;
            mc_rq_stall       <= 1'b0;
            err_ovf           <= 1'b0;
            flush_pend        <= 1'b0;
            mc_rs_flush_cmplt <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (pop) {cur_cmd, cur_scmd, cur_idx, cur_data, cur_rtnctl} <= q_rdata;
            // Response fields are captured once and then held through RESP.
            if (access) begin
                mc_rs_cmd    <= cur_wr ? RS_CMD_WR_CMPLT : RS_CMD_RD_DATA;
                mc_rs_scmd   <= cur_scmd;
                mc_rs_rtnctl <= cur_rtnctl;
                mc_rs_data   <= cur_wr ? 64'd0 : mem[cur_idx];
            end
            mc_rq_stall       <= (occ_next >= CW'(FIFO_DEPTH - 2));
            err_ovf           <= err_ovf || (mc_rq_vld && !push);
            flush_pend        <= mc_rq_flush || (flush_pend && !flush_done);
            mc_rs_flush_cmplt <= flush_done;
        end
    end

    always_ff @(posedge clk) begin
        if (access && cur_wr) mem[cur_idx] <= cur_data;
    end

endmodule

// File: tb/tb_mc_port_responder.sv
// Randomised bench for mc_port_responder: an in-order memory model predicts
// every response; directed scenarios cover latency, stall, overflow, flush, reset.
module tb_mc_port_responder;

    localparam int RW    = 32;
    localparam int DEPTH = 8;
    localparam int LAT   = 4;
    localparam int MW    = 256;

    typedef struct packed {
        logic [2:0]    cmd;
        logic [3:0]    scmd;
        logic [63:0]   data;
        logic [RW-1:0] rtnctl;
    } rs_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mc_rq_vld, mc_rq_flush, mc_rq_stall, mc_rs_vld, mc_rs_stall;
    logic          mc_rs_flush_cmplt, err_ovf;
    logic [2:0]    mc_rq_cmd, mc_rs_cmd;
    logic [3:0]    mc_rq_scmd, mc_rs_scmd;
    logic [47:0]   mc_rq_vadr;
    logic [1:0]    mc_rq_size;
    logic [63:0]   mc_rq_data, mc_rs_data;
    logic [RW-1:0] mc_rq_rtnctl, mc_rs_rtnctl;

    int   n_vec = 0, n_bad = 0;
    rs_t  got_q[$], exp_q[$];
    logic [63:0] mem_m [MW];
    bit   written [MW];
    int   cyc = 0, flush_cnt = 0, flush_cyc = 0, last_rs_cyc = 0;

    mc_port_responder #(
        .RTNCTL_WIDTH (RW),
        .FIFO_DEPTH   (DEPTH),
        .LATENCY      (LAT),
        .MEM_WORDS    (MW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .mc_rq_vld         (mc_rq_vld),
        .mc_rq_cmd         (mc_rq_cmd),
        .mc_rq_scmd        (mc_rq_scmd),
        .mc_rq_vadr        (mc_rq_vadr),
        .mc_rq_size        (mc_rq_size),
        .mc_rq_data        (mc_rq_data),
        .mc_rq_rtnctl      (mc_rq_rtnctl),
        .mc_rq_flush       (mc_rq_flush),
        .mc_rq_stall       (mc_rq_stall),
        .mc_rs_vld         (mc_rs_vld),
        .mc_rs_cmd         (mc_rs_cmd),
        .mc_rs_scmd        (mc_rs_scmd),
        .mc_rs_data        (mc_rs_data),
        .mc_rs_rtnctl      (mc_rs_rtnctl),
        .mc_rs_stall       (mc_rs_stall),
        .mc_rs_flush_cmplt (mc_rs_flush_cmplt),
        .err_ovf           (err_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Capture every completed response and every flush-complete pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mc_rs_vld && !mc_rs_stall) begin
                got_q.push_back({mc_rs_cmd, mc_rs_scmd, mc_rs_data, mc_rs_rtnctl});
                last_rs_cyc = cyc;
            end
            if (mc_rs_flush_cmplt) begin
                flush_cnt++;
                flush_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: requests complete in program order against a flat word array.
    function automatic void model_accept();
        int  idx;
        rs_t e;
        idx      = int'(mc_rq_vadr[10:3]);
        e.scmd   = mc_rq_scmd;
        e.rtnctl = mc_rq_rtnctl;
        if (mc_rq_cmd == 3'd2) begin
            mem_m[idx]   = mc_rq_data;
            written[idx] = 1'b1;
            e.cmd        = 3'd3;
            e.data       = 64'd0;
        end else begin
            e.cmd  = 3'd2;
            e.data = mem_m[idx];
        end
        exp_q.push_back(e);
    endfunction

    task automatic drive_req(input logic [2:0] cmd, input logic [47:0] vadr,
                             input logic [63:0] data, input logic [RW-1:0] tag);
        mc_rq_vld    = 1'b1;
        mc_rq_cmd    = cmd;
        mc_rq_scmd   = 4'($urandom);
        mc_rq_vadr   = vadr;
        mc_rq_size   = 2'($urandom);
        mc_rq_data   = data;
        mc_rq_rtnctl = tag;
    endtask

    task automatic issue(input logic [2:0] cmd, input logic [47:0] vadr,
                         input logic [63:0] data, input logic [RW-1:0] tag, input bit model);
        drive_req(cmd, vadr, data, tag);
        if (model) model_accept();
        tick();
        mc_rq_vld = 1'b0;
    endtask

    task automatic drive_random_req();
        logic [2:0]  cmd;
        logic [47:0] v;
        int          idx;
        idx  = $urandom_range(0, 7) * 4 + 1;
        cmd  = 3'($urandom_range(0, 7));
        if (!written[idx]) cmd = 3'd2;
        v    = 48'({$urandom, $urandom});
        v[10:3] = 8'(idx);
        drive_req(cmd, v, {$urandom, $urandom}, $urandom);
    endtask

    task automatic drain(input string name);
        int k = 0;
        mc_rs_stall = 1'b0;
        while (got_q.size() < exp_q.size() && k < 400) begin
            tick();
            k++;
        end
        repeat (LAT + 4) tick();
        n_vec++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL %s count: got %0d responses, expected %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL %s rsp%0d: got %h expected %h", name, i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // Source that reacts to mc_rq_stall two cycles late.
    task automatic run_source(input int n, input int hold, input int gap_pct, input int rss_pct);
        bit h1 = 0, h2 = 0, s_now, allow;
        int sent = 0, c = 0;
        while (sent < n && c < 2000) begin
            s_now = mc_rq_stall;
            allow = !h2;
            h2    = h1;
            h1    = s_now;
            mc_rs_stall = (c < hold) || ($urandom_range(0, 99) < rss_pct);
            if (allow && $urandom_range(0, 99) >= gap_pct) begin
                drive_random_req();
                model_accept();
                sent++;
            end else begin
                mc_rq_vld = 1'b0;
            end
            tick();
            c++;
        end
        mc_rq_vld = 1'b0;
        n_vec++;
        if (sent != n) begin
            n_bad++;
            $display("FAIL source_progress: sent %0d, required %0d", sent, n);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        n_vec++;
        if ({mc_rq_stall, mc_rs_vld, mc_rs_flush_cmplt, err_ovf, mc_rs_cmd, mc_rs_scmd,
             mc_rs_data, mc_rs_rtnctl} !== '0) begin
            n_bad++;
            $display("FAIL %s: stall=%b vld=%b fc=%b ovf=%b cmd=%h data=%h rtn=%h, all required 0",
                     name, mc_rq_stall, mc_rs_vld, mc_rs_flush_cmplt, err_ovf, mc_rs_cmd,
                     mc_rs_data, mc_rs_rtnctl);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        {mc_rq_vld, mc_rq_flush, mc_rs_stall} = '0;
        drive_req(3'd0, '0, '0, '0);
        mc_rq_vld = 1'b0;
        #2;
        check_reset_outputs("reset_state");
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_latency();
        drive_req(3'd2, 48'h40, 64'hDEAD_BEEF, 32'h11);
        model_accept();
        tick();
        mc_rq_vld = 1'b0;
        for (int k = 0; k <= LAT + 1; k++) begin
            @(negedge clk);
            if (k == LAT) begin
                n_vec++;
                if (mc_rs_vld !== 1'b0) begin
                    n_bad++;
                    $display("FAIL latency_early: vld=%b at accept+%0d, required 0", mc_rs_vld, k);
                end
            end
            if (k == LAT + 1) begin
                n_vec++;
                if (mc_rs_vld !== 1'b1 || mc_rs_cmd !== 3'd3 || mc_rs_rtnctl !== 32'h11) begin
                    n_bad++;
                    $display("FAIL latency_resp: vld=%b cmd=%0d rtn=%h, required 1/3/11",
                             mc_rs_vld, mc_rs_cmd, mc_rs_rtnctl);
                end
            end
            @(posedge clk);
        end
        #1;
        drain("latency");
    endtask

    task automatic test_back_to_back();
        issue(3'd2, 48'h40, 64'hDEAD_BEEF, 32'h21, 1);
        issue(3'd1, 48'h40, 64'h0, 32'h22, 1);
        drain("wr_rd_b2b");
    endtask

    task automatic test_random();
        run_source(40, 0, 30, 25);
        drain("random");
        n_vec++;
        if (err_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL random_ovf: err_ovf=%b, required 0", err_ovf);
        end
    endtask

    task automatic test_burst();
        run_source(10, 25, 0, 0);
        drain("burst_honoured");
        n_vec++;
        if (err_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL burst_ovf: err_ovf=%b, required 0", err_ovf);
        end
    endtask

    task automatic test_stall_hold();
        rs_t e, obs;
        int  k = 0;
        mc_rs_stall = 1'b1;
        issue(3'd1, 48'h40, 64'h0, 32'h33, 1);
        e = exp_q[0];
        @(negedge clk);
        while (!mc_rs_vld && k < 30) begin
            @(negedge clk);
            k++;
        end
        for (int i = 0; i < 7; i++) begin
            obs = {mc_rs_cmd, mc_rs_scmd, mc_rs_data, mc_rs_rtnctl};
            n_vec++;
            if (mc_rs_vld !== 1'b1 || obs !== e) begin
                n_bad++;
                $display("FAIL stall_hold cyc%0d: vld=%b out=%h required 1/%h", i, mc_rs_vld, obs, e);
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        drain("stall_release");
    endtask

    task automatic test_flush();
        flush_cnt = 0;
        for (int i = 0; i < 3; i++) issue(3'd2, 48'(8 * (40 + i)), {$urandom, $urandom}, 32'(i), 1);
        mc_rq_flush = 1'b1; tick(); mc_rq_flush = 1'b0;
        tick();
        mc_rq_flush = 1'b1; tick(); mc_rq_flush = 1'b0;
        drain("flush_wrs");
        n_vec++;
        if (flush_cnt != 1 || flush_cyc <= last_rs_cyc) begin
            n_bad++;
            $display("FAIL flush_busy: pulses=%0d at cyc %0d last_rsp %0d, required 1 after last rsp",
                     flush_cnt, flush_cyc, last_rs_cyc);
        end
        flush_cnt = 0;
        mc_rq_flush = 1'b1; tick(); mc_rq_flush = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (mc_rs_flush_cmplt !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_idle: cmplt=%b next cycle, required 1", mc_rs_flush_cmplt);
        end
        @(posedge clk); #1;
        repeat (5) tick();
        n_vec++;
        if (flush_cnt != 1) begin
            n_bad++;
            $display("FAIL flush_idle_count: pulses=%0d, required 1", flush_cnt);
        end
    endtask

    task automatic test_overflow();
        mc_rs_stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_req(3'd2, 48'(8 * (60 + i)), {$urandom, $urandom}, 32'(100 + i));
            if (i < DEPTH + 1) model_accept();
            tick();
        end
        mc_rq_vld = 1'b0;
        n_vec++;
        if (err_ovf !== 1'b1) begin
            n_bad++;
            $display("FAIL overflow_flag: err_ovf=%b, required 1", err_ovf);
        end
        drain("overflow");
    endtask

    task automatic test_reset_mid();
        issue(3'd2, 48'h80, 64'h1234_5678_9ABC_DEF0, 32'h44, 1);
        drain("pre_reset_wr");
        for (int i = 0; i < 4; i++) issue(3'd2, 48'h80, {$urandom, $urandom}, 32'(200 + i), 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid");
        tick();
        tick();
        rst_n = 1'b1;
        got_q.delete();
        repeat (15) tick();
        n_vec++;
        if (got_q.size() != 0) begin
            n_bad++;
            $display("FAIL reset_discard: got %0d responses, required 0", got_q.size());
        end
        issue(3'd1, 48'h80, 64'h0, 32'h45, 1);
        drain("post_reset_rd");
    endtask

    initial begin
        mc_rq_flush = 1'b0;
        mc_rs_stall = 1'b0;
        test_reset();
        test_latency();
        test_back_to_back();
        test_random();
        test_burst();
        test_stall_hold();
        test_flush();
        test_overflow();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
